// File: rtl/netid_writer.sv
// netid_writer: one-wire transmitter for an 8-bit net-ID frame (start, 8 data bits MSB-first, stop).
// Define NETID_WRITER_PARITY_EN to insert an even-parity bit between the data and stop bits.
module netid_writer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter logic [7:0]  NETID        = 8'h7D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sel_custom,
    input  logic [7:0] code,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

`ifdef NETID_WRITER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

    state_t     r_state;
    logic [7:0] r_cyc;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_serial;
    logic       r_busy;
    logic       r_done;
`ifdef NETID_WRITER_PARITY_EN
    logic       r_parity;
`endif

    logic       w_bit_end;
    logic [7:0] w_load;

    assign w_bit_end = (r_cyc == LAST_CYC);
    assign w_load    = sel_custom ? code : NETID;

    // NOTE: outputs are computed from the next state and registered here with <=, so the
    // line level always lines up with the state it belongs to and no input reaches a pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cyc    <= 8'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef NETID_WRITER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    if (start) begin
                        r_state  <= START;
                        r_shift  <= w_load;
                        r_cyc    <= 8'd0;
                        r_bit    <= 3'd0;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef NETID_WRITER_PARITY_EN
                        // Parity is taken at load time because the shift register is consumed.
                        r_parity <= ^w_load;
`endif
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state  <= DATA;
                        r_cyc    <= 8'd0;
                        r_serial <= r_shift[7];
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cyc <= 8'd0;
                        if (r_bit == 3'd7) begin
`ifdef NETID_WRITER_PARITY_EN
                            r_state  <= PARITY;
                            r_serial <= r_parity;
`else
                            r_state  <= STOP;
                            r_serial <= 1'b1;
`endif
                        end else begin
                            r_bit    <= r_bit + 3'd1;
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_serial <= r_shift[6];
                        end
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
`ifdef NETID_WRITER_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state  <= STOP;
                        r_cyc    <= 8'd0;
                        r_serial <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_state  <= IDLE;
                        r_cyc    <= 8'd0;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_netid_writer.sv
// tb_netid_writer: table-driven frames plus hand-written corner sequences, checked per cycle
// against a queue of expected {serial_out, busy, done} samples; honours NETID_WRITER_PARITY_EN.
module tb_netid_writer;

    typedef struct packed {
        logic serial;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic       sel;
        logic [7:0] code;
        logic [7:0] code_after;
        logic [7:0] exp_byte;
    } vec_t;

    localparam logic [7:0] NETID    = 8'h7D;
    localparam exp_t       IDLE_EXP = exp_t'{1'b1, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sel_custom;
    logic [7:0] code;
    logic       serial4, busy4, done4;
    logic       start2, sel2;
    logic [7:0] code2;
    logic       serial2, busy2, done2;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q4[$];
    exp_t q2[$];
    exp_t e4, e2;

    netid_writer #(.CLKS_PER_BIT(4), .NETID(NETID)) u_dut (
        .clk(clk), .reset(rst_n), .start(start), .sel_custom(sel_custom), .code(code),
        .serial_out(serial4), .busy(busy4), .done(done4)
    );

    netid_writer #(.CLKS_PER_BIT(2), .NETID(NETID)) u_dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .sel_custom(sel2), .code(code2),
        .serial_out(serial2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got {serial,busy,done}=%b, expected %b", name, $time, act, exp);
        end
    endtask

    // Expected per-cycle samples of one whole frame, ending with the done cycle.
    task automatic push_frame(input logic [7:0] b, input int cpb, input bit to_dut2);
        exp_t seq[$];
        for (int c = 0; c < cpb; c++) seq.push_back(exp_t'{1'b0, 1'b1, 1'b0});
        for (int i = 7; i >= 0; i--)
            for (int c = 0; c < cpb; c++) seq.push_back(exp_t'{b[i], 1'b1, 1'b0});
`ifdef NETID_WRITER_PARITY_EN
        for (int c = 0; c < cpb; c++) seq.push_back(exp_t'{^b, 1'b1, 1'b0});
`endif
        for (int c = 0; c < cpb; c++) seq.push_back(exp_t'{1'b1, 1'b1, 1'b0});
        seq.push_back(exp_t'{1'b1, 1'b0, 1'b1});
        foreach (seq[k]) begin
            if (to_dut2) q2.push_back(seq[k]);
            else         q4.push_back(seq[k]);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge; an empty queue means idle.
    always @(posedge clk) begin
        #1;
        if (q4.size() > 0) e4 = q4.pop_front();
        else               e4 = IDLE_EXP;
        check("dut4_line", {serial4, busy4, done4}, e4);
        if (q2.size() > 0) e2 = q2.pop_front();
        else               e2 = IDLE_EXP;
        check("dut2_line", {serial2, busy2, done2}, e2);
    end

    // NOTE: stimulus is driven with blocking assignments on the falling edge, half a cycle
    // away from the edge where the DUT samples it.
    task automatic drive(input logic st, input logic sl, input logic [7:0] cd, input logic [7:0] exp_b);
        @(negedge clk);
        start      = st;
        sel_custom = sl;
        code       = cd;
        if (st && q4.size() == 0) push_frame(exp_b, 4, 1'b0);
    endtask

    task automatic wait_idle4(input int max_cycles);
        int n = 0;
        while (q4.size() != 0 && n < max_cycles) begin
            drive(1'b0, sel_custom, code, 8'h00);
            n++;
        end
        n_checks++;
        if (q4.size() != 0) begin
            n_fail++;
            $display("FAIL dut4_frame_timeout: %0d samples pending after %0d cycles, expected 0",
                     q4.size(), max_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n;
        vecs[0] = '{1'b0, 8'h00, 8'hFF, NETID};
        vecs[1] = '{1'b1, 8'hA5, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 8'h01, 8'h80, 8'h01};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF};
        vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{1'b0, 8'h3C, 8'hA5, NETID};

        rst_n = 1'b0; start = 1'b0; sel_custom = 1'b0; code = 8'h00;
        start2 = 1'b0; sel2 = 1'b0; code2 = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Default ID frame from a single start pulse.
        drive(1'b1, 1'b0, 8'h00, NETID);
        wait_idle4(100);
        drive(1'b0, 1'b0, 8'h00, 8'h00);

        // Table: inputs are altered mid-frame; the latched byte must not change.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].sel, vecs[i].code, vecs[i].exp_byte);
            repeat (10) drive(1'b0, ~vecs[i].sel, vecs[i].code_after, 8'h00);
            wait_idle4(100);
            drive(1'b0, 1'b0, 8'h00, 8'h00);
        end

        // Start pulses while busy are ignored: one frame, one done pulse.
        drive(1'b1, 1'b1, 8'h5A, 8'h5A);
        for (int c = 1; c <= 45; c++) drive((c == 5 || c == 20), 1'b1, 8'h5A, 8'h5A);
        wait_idle4(100);

        // Back-to-back frames on the CLKS_PER_BIT=2 instance with start held high.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start2 = 1'b1; sel2 = 1'b1; code2 = 8'hC3;
            if (q2.size() == 0) push_frame(8'hC3, 2, 1'b1);
        end
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (q2.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q2.size() != 0) begin
            n_fail++;
            $display("FAIL dut2_frame_timeout: %0d samples pending, expected 0", q2.size());
        end

        // Reset during data bit 3 abandons the frame at once and gives no done pulse.
        drive(1'b1, 1'b1, 8'hA5, 8'hA5);
        repeat (21) drive(1'b0, 1'b1, 8'hA5, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        q4.delete();
        q2.delete();
        #1;
        check("reset_mid_frame", {serial4, busy4, done4}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h00, NETID);
        wait_idle4(100);
        repeat (5) drive(1'b0, 1'b0, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/netid_writer.md
Name: netid_writer

Overview:
- Serial transmitter for an 8-bit net-ID code. It sends the code that the downstream ID reader/decoder checks.
- One frame per start request: idle-high line, start bit, 8 data bits MSB-first, stop bit.
- Sits between the switch/ID source and the single-wire link to the reader.
- Frame content and timing are deterministic per cycle, so the reader side can be checked bit by bit.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
- NETID, 8'h7D, built-in ID code sent when sel_custom=0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- sel_custom  input  1  1 = send code input; 0 = send NETID. Sampled with start.
- code  input  8  custom ID byte; latched when start is accepted.
- serial_out  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - serial_out=1, busy=0, done=0.
  - State=IDLE; bit counter, cycle counter and shift register cleared.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned with no done pulse.
- States: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE:
  - serial_out=1, busy=0.
  - On a rising edge with start=1, load shift register with (sel_custom ? code : NETID), clear counters, go to START.
  - busy=1 and serial_out=0 from the next cycle.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - serial_out = shift register bit 7.
  - After each CLKS_PER_BIT cycles, shift left by one; after 8 bits, go to STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame completion:
  - On the edge leaving STOP, done=1 for exactly one cycle while in IDLE; busy=0 in that same cycle.
  - Frame length is 10*CLKS_PER_BIT busy cycles (11*CLKS_PER_BIT with parity).
- start while busy=1: ignored. No queuing, and the latched byte is unaffected.
- start=1 in the done cycle: accepted, giving back-to-back frames with exactly one idle-high cycle between stop and the next start bit.
- start held high continuously: a new frame starts each time IDLE is entered.
- code and sel_custom changes after acceptance have no effect on the current frame.
- Cycle counter width: 8 bits. Bit counter: 0..7, no wrap past 7.
- CLKS_PER_BIT=1: every state lasts one cycle; same sequence rules apply.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: NETID_WRITER_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - serial_out = even parity (XOR of the 8 latched bits) for CLKS_PER_BIT cycles.
  - Frame is 11*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - Frame is 10*CLKS_PER_BIT cycles.

Test Plan:
- Default ID frame: reset low 3 cycles then high; start=1, sel_custom=0 for one cycle, CLKS_PER_BIT=4.
  - serial_out = 0 (4 cycles), then 0,1,1,1,1,1,0,1 (4 cycles each), then 1 (4 cycles).
  - busy high 40 cycles; done pulses once on cycle 41.
- Custom code: sel_custom=1, code=8'hA5, start pulse.
  - Data bits 1,0,1,0,0,1,0,1 MSB-first.
  - Changing code to 8'h00 mid-frame has no effect.
- Start while busy: extra start pulses at frame cycles 5 and 20.
  - Exactly one frame and one done pulse; line idle high afterwards.
- Back-to-back: start held at 1 for 100 cycles, CLKS_PER_BIT=2.
  - Frames of 20 busy cycles, each separated by one idle-high done cycle.
- Reset mid-frame: assert reset during data bit 3.
  - serial_out=1, busy=0 in the same cycle, no done pulse.
  - A next start after release yields a complete, correct frame.
- Parity build: NETID_WRITER_PARITY_EN defined, code=8'h7D.
  - Parity bit = 0; frame 44 cycles at CLKS_PER_BIT=4.
  - With code=8'h01, parity bit = 1.
